// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage : instruction fetch with in-order imem requests, a DEPTH-entry
//            instruction buffer, and redirect/flush of in-flight beats.
// Rev 1.0
// ============================================================================
module if_stage #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               DEPTH        = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  input  logic            i_id_ready,
  output logic            o_misaligned
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_sum_w = c_cnt_w + 2;

  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);
  localparam logic [c_sum_w-1:0] c_depth    = c_sum_w'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
  localparam logic [XLEN-1:0]    c_step     = XLEN'(4);

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    head_pc_q, head_pc_d;
  logic [c_cnt_w-1:0] outstanding_q, outstanding_d;
  logic [c_cnt_w-1:0] drop_cnt_q, drop_cnt_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0]    mem_q [DEPTH];

  logic               w_req;
  logic               w_gnt;
  logic               w_drop_beat;
  logic               w_push;
  logic               w_pop;
  logic [c_sum_w-1:0] w_used;
  logic [c_cnt_w:0]   w_flush_sum;
  logic [c_cnt_w:0]   w_flush_left;
  logic [XLEN-1:0]    w_redirect_pc;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_last) ? '0 : p + c_ptr_one;
  endfunction

  // Every fetch already granted or still to be dropped holds a buffer slot,
  // so a returning beat always finds room and the FIFO cannot overflow.
  always_comb begin
    w_used        = c_sum_w'(outstanding_q) + c_sum_w'(drop_cnt_q) + c_sum_w'(count_q);
    w_req         = i_rstn & ~i_redirect & (w_used < c_depth);
    w_gnt         = w_req & i_imem_gnt;
    w_drop_beat   = i_imem_rvalid & (drop_cnt_q != '0);
    w_pop         = (count_q != '0) & i_id_ready & ~i_redirect;
    w_push        = i_imem_rvalid & (drop_cnt_q == '0) & (outstanding_q != '0)
                  & ~i_redirect & ((count_q != c_full) | w_pop);
    w_redirect_pc = {i_redirect_pc[XLEN-1:2], 2'b00};
    w_flush_sum   = {1'b0, drop_cnt_q} + {1'b0, outstanding_q};
    w_flush_left  = (i_imem_rvalid && (w_flush_sum != '0)) ? w_flush_sum - 1'b1 : w_flush_sum;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_pc_d     = head_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (i_redirect) begin
      // A beat arriving now belongs to the flushed stream and retires one drop.
      fetch_pc_d    = w_redirect_pc;
      head_pc_d     = w_redirect_pc;
      outstanding_d = '0;
      drop_cnt_d    = c_cnt_w'(w_flush_left);
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end else begin
      if (w_gnt) begin
        fetch_pc_d = fetch_pc_q + c_step;
      end
      if (w_pop) begin
        head_pc_d = head_pc_q + c_step;
        rd_ptr_d  = ptr_inc(rd_ptr_q);
      end
      if (w_push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (w_drop_beat) begin
        drop_cnt_d = drop_cnt_q - c_cnt_one;
      end
      case ({w_gnt, w_push})
        2'b10:   outstanding_d = outstanding_q + c_cnt_one;
        2'b01:   outstanding_d = outstanding_q - c_cnt_one;
        default: outstanding_d = outstanding_q;
      endcase
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + c_cnt_one;
        2'b01:   count_d = count_q - c_cnt_one;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fetch_pc_q    <= RESET_VECTOR;
      head_pc_q     <= RESET_VECTOR;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= i_imem_rdata;
    end
  end

  assign o_imem_req   = w_req;
  assign o_imem_addr  = fetch_pc_q;
  assign o_if_valid   = (count_q != '0);
  assign o_if_instr   = mem_q[rd_ptr_q];
  assign o_if_pc      = head_pc_q;
  assign o_misaligned = i_rstn & i_redirect & (|i_redirect_pc[1:0]);

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// tb_if_stage : directed self-checking bench for if_stage with an in-order
//               imem responder model.
// Rev 1.0
// ============================================================================
module tb_if_stage;

  logic        clk;
  logic        rstn;
  logic        gnt, rvalid, redirect, ready;
  logic [31:0] rdata, redirect_pc;
  logic        req, ifv, mis;
  logic [31:0] addr, instr, ifpc;
  logic        req2, ifv2, mis2;
  logic [31:0] addr2, instr2, ifpc2;

  int          total, bad;
  int          grants, pops;
  logic        gnt_en, resp_en;
  logic [31:0] exp_fetch, exp_head, exp2;
  logic [31:0] q[$];

  if_stage #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .DEPTH(4)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_if_valid(ifv), .o_if_instr(instr), .o_if_pc(ifpc),
    .i_id_ready(ready), .o_misaligned(mis)
  );

  if_stage #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
    .i_clk(clk), .i_rstn(rstn),
    .o_imem_req(req2), .o_imem_addr(addr2), .i_imem_gnt(gnt),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_if_valid(ifv2), .o_if_instr(instr2), .o_if_pc(ifpc2),
    .i_id_ready(ready), .o_misaligned(mis2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive imem, check grant/pop against the model, then clock.
  task automatic step();
    gnt    = gnt_en;
    rvalid = resp_en && (q.size() > 0);
    rdata  = rvalid ? mem_word(q[0]) : 32'h0;
    #1;
    if (redirect) begin
      check("redir_req_low", 32'(req), 32'd0);
      check("misaligned", 32'(mis), 32'(|redirect_pc[1:0]));
    end
    if (req && gnt) begin
      check("fetch_addr", addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      grants++;
      q.push_back(addr);
    end
    if (ifv && ready && !redirect) begin
      check("head_pc", ifpc, exp_head);
      check("head_instr", instr, mem_word(exp_head));
      exp_head = exp_head + 32'd4;
      pops++;
    end
    if (rvalid) void'(q.pop_front());
    if (redirect) begin
      exp_fetch = {redirect_pc[31:2], 2'b00};
      exp_head  = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    q.delete();
    gnt = 1'b1; gnt_en = 1'b1; resp_en = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0102;
    #3;
    check("rst_req", 32'(req), 32'd0);
    check("rst_valid", 32'(ifv), 32'd0);
    check("rst_mis", 32'(mis), 32'd0);
    redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_fetch = 32'h0; exp_head = 32'h0; grants = 0; pops = 0;
  endtask

  initial begin
    total = 0; bad = 0;
    rstn = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b0;
    gnt_en = 1'b0; resp_en = 1'b0;
    exp_fetch = 32'h0; exp_head = 32'h0; grants = 0; pops = 0;
    @(posedge clk); #1;

    // Streaming fetch, plus wrap of the high reset vector on the second DUT.
    do_reset();
    resp_en = 1'b1;
    #1;
    check("req_after_rst", 32'(req), 32'd1);
    check("rst_head_pc", ifpc, 32'h0);
    exp2 = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      check("wrap_addr", addr2, exp2);
      exp2 = exp2 + 32'd4;
      step();
    end
    repeat (9) step();
    check("stream_grants", 32'(grants), 32'd12);
    check("stream_pops", 32'(pops), 32'd10);

    // Decode stalled: buffer fills and requests stop.
    do_reset();
    ready = 1'b0; resp_en = 1'b1;
    repeat (10) step();
    check("full_grants", 32'(grants), 32'd4);
    check("full_req_low", 32'(req), 32'd0);
    check("full_count", 32'(dut.count_q), 32'd4);
    check("full_head_pc", ifpc, 32'h0);
    check("full_head_instr", instr, mem_word(32'h0));

    // Two beats in flight when redirected.
    do_reset();
    ready = 1'b0; resp_en = 1'b0;
    repeat (2) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    #1;
    check("drop_after_redir", 32'(dut.drop_cnt_q), 32'd2);
    check("out_after_redir", 32'(dut.outstanding_q), 32'd0);
    check("redir_addr", addr, 32'h0000_0100);
    check("redir_req", 32'(req), 32'd1);
    resp_en = 1'b1; ready = 1'b1;
    pops = 0;
    repeat (8) step();
    check("redir_pops", 32'(pops > 0), 32'd1);

    // Misaligned redirect target.
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect = 1'b0;
    #1;
    check("mis_clear", 32'(mis), 32'd0);
    check("mis_addr", addr, 32'h0000_0100);
    pops = 0;
    repeat (10) step();
    check("mis_pops", 32'(pops > 0), 32'd1);

    // Redirect coincident with a returning beat and a pop.
    do_reset();
    ready = 1'b0; resp_en = 1'b0;
    repeat (3) step();
    resp_en = 1'b1;
    step();
    check("pre_count", 32'(dut.count_q), 32'd1);
    check("pre_out", 32'(dut.outstanding_q), 32'd3);
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    #1;
    check("coin_count", 32'(dut.count_q), 32'd0);
    check("coin_drop", 32'(dut.drop_cnt_q), 32'd2);
    check("coin_out", 32'(dut.outstanding_q), 32'd0);
    check("coin_valid", 32'(ifv), 32'd0);
    pops = 0;
    repeat (10) step();
    check("coin_pops", 32'(pops >= 3), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC, address and instruction width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC loaded at reset.
REQ-003 SHALL have parameter DEPTH, default 4, legal 2..16: instruction buffer entries and maximum in-flight plus buffered fetches.
REQ-004 SHALL have port i_clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-005 SHALL have port i_rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port o_imem_req, output, 1 bit: fetch request valid.
REQ-007 SHALL have port o_imem_addr, output, XLEN bits: fetch address, equal to the current fetch PC.
REQ-008 SHALL have port i_imem_gnt, input, 1 bit: request accepted when sampled high with o_imem_req.
REQ-009 SHALL have port i_imem_rvalid, input, 1 bit: one response beat; responses return in request order, at least 1 cycle after grant.
REQ-010 SHALL have port i_imem_rdata, input, XLEN bits: instruction word for the response beat.
REQ-011 SHALL have port i_redirect, input, 1 bit: branch/jump redirect from EX.
REQ-012 SHALL have port i_redirect_pc, input, XLEN bits: redirect target.
REQ-013 SHALL have port o_if_valid, output, 1 bit: buffer head holds a valid instruction.
REQ-014 SHALL have port o_if_instr, output, XLEN bits: head instruction.
REQ-015 SHALL have port o_if_pc, output, XLEN bits: PC of the head instruction.
REQ-016 SHALL have port i_id_ready, input, 1 bit: decode accepts the head when high with o_if_valid.
REQ-017 SHALL have port o_misaligned, output, 1 bit: one-cycle pulse on a redirect whose target has nonzero bits [1:0].

Function
REQ-018 SHALL keep fetch_pc, head_pc, outstanding (live in-flight), drop_cnt (in-flight to be discarded) and a DEPTH-entry FIFO with count.
REQ-019 SHALL assert o_imem_req combinationally when i_redirect is low and outstanding + drop_cnt + count < DEPTH.
REQ-020 SHALL, on grant, advance fetch_pc by 4 (modulo 2^XLEN, wrap from all-ones to 0) and increment outstanding.
REQ-021 SHALL, on i_imem_rvalid with drop_cnt > 0, discard the beat and decrement drop_cnt.
REQ-022 SHALL, on i_imem_rvalid with drop_cnt = 0, push i_imem_rdata to the FIFO and decrement outstanding.
REQ-023 SHALL drive o_if_valid = (count > 0), with o_if_instr/o_if_pc from the head combinationally.
REQ-024 SHALL pop the head on o_if_valid && i_id_ready and advance head_pc by 4; latency from rvalid to o_if_valid is 1 cycle.
REQ-025 SHALL handle push and pop in the same cycle, including when full, leaving count unchanged.
REQ-026 SHALL, on i_redirect, load fetch_pc and head_pc with {i_redirect_pc[XLEN-1:2], 2'b00} and clear count.
REQ-027 SHALL, on i_redirect, set drop_cnt to drop_cnt + outstanding - (rvalid this cycle ? 1 : 0) and clear outstanding.
REQ-028 SHALL, in a redirect cycle, discard any response beat and ignore any pop.
REQ-029 SHALL pulse o_misaligned for exactly the redirect cycle when i_redirect_pc[1:0] != 0; the redirect is still taken.
REQ-030 SHALL issue the first post-redirect request in the cycle after redirect, if REQ-019 allows it.
REQ-031 SHALL never overflow the FIFO.
REQ-032 SHALL never underflow outstanding or drop_cnt.

Reset
REQ-033 SHALL, while i_rstn is low, set fetch_pc = head_pc = RESET_VECTOR and outstanding = drop_cnt = count = 0.
REQ-034 SHALL, while i_rstn is low, hold o_imem_req, o_if_valid and o_misaligned at 0.
REQ-035 SHALL allow o_imem_req to assert in the first cycle after i_rstn rises.
REQ-036 SHALL, on reset mid-operation, abandon in-flight fetches; the bench SHALL not return their responses.

Verification
REQ-037 Reset release, gnt=1, rvalid 1 cycle after grant, ready=1 -> addresses 0,4,8,...; o_if_pc 0,4,8 in order.
REQ-038 ready=0, gnt=1, DEPTH=4 -> exactly 4 grants; o_imem_req then stays low with count=4.
REQ-039 2 in flight, redirect to 0x100 -> both beats dropped; next o_imem_addr=0x100; first o_if_pc=0x100.
REQ-040 Redirect to 0x102 -> o_misaligned high 1 cycle; fetch resumes at 0x100.
REQ-041 Redirect coincident with an rvalid beat and a pop -> beat discarded, count=0, drop_cnt = outstanding-1.
REQ-042 RESET_VECTOR=32'hFFFF_FFF8, gnt=1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
